// File: rtl/cpu_host_pkg.sv
// Shared types and default widths for the CPU host-port run sequencer.
package cpu_host_pkg;

   localparam int unsigned DEF_NUM_OPS     = 2;
   localparam int unsigned DEF_OP_W        = 8;
   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_ADDR_W      = 32;
   localparam int unsigned DEF_SETTLE_CYC  = 2;
   localparam int unsigned DEF_BSY_TIMEOUT = 4096;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      SETTLE,
      START,
      WAIT_HI,
      WAIT_LO,
      CAPTURE,
      DONE,
      ERR
   } state_e;

endpackage

// File: rtl/run_timeout_ctr.sv
// Saturating cycle counter for a bsy wait phase; expired flags the LIMIT-th waited cycle.
module run_timeout_ctr #(
   parameter int unsigned LIMIT = 4096
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_en,
   output logic o_expired_c
);

   // LIMIT of zero means wait forever; keep a one-bit counter so widths stay legal.
   localparam int unsigned     CNT_W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] SAT  = CNT_W'((LIMIT == 0) ? 1 : LIMIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT == 0) ? 0 : LIMIT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_load) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != SAT)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_expired_c = (LIMIT != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/cpu_run_sequencer.sv
// CPU host-port run sequencer: load operands, pulse start, track bsy, capture dout.
module cpu_run_sequencer
   import cpu_host_pkg::*;
#(
   parameter int unsigned NUM_OPS     = DEF_NUM_OPS,
   parameter int unsigned OP_W        = DEF_OP_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int unsigned BSY_TIMEOUT = DEF_BSY_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    go,
   input  logic [NUM_OPS*OP_W-1:0] ops,
   output logic                    wen,
   output logic [ADDR_W-1:0]       haddr,
   output logic [DATA_W-1:0]       hdin,
   output logic                    start,
   input  logic                    bsy,
   input  logic [DATA_W-1:0]       dout,
   output logic [DATA_W-1:0]       result,
   output logic                    result_valid,
   output logic                    running,
   output logic                    timeout_err
);

   localparam int unsigned      OPS_W    = NUM_OPS * OP_W;
   localparam int unsigned      IDX_W    = $clog2(NUM_OPS + 1);
   localparam int unsigned      SET_W    = $clog2(SETTLE_CYC + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);
   localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETTLE_CYC - 1);

   state_e           r_state;
   logic [OPS_W-1:0] r_ops;
   logic [IDX_W-1:0] r_idx;
   logic [SET_W-1:0] r_settle;

   logic w_tmr_load;
   logic w_tmr_en;
   logic w_tmr_expired;

   // Timer restarts on entry to each bsy phase.
   assign w_tmr_load = (r_state == START) || ((r_state == WAIT_HI) && bsy);
   assign w_tmr_en   = (r_state == WAIT_HI) || (r_state == WAIT_LO);

   run_timeout_ctr #(
      .LIMIT(BSY_TIMEOUT)
   ) u_tmr (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_load     (w_tmr_load),
      .i_en       (w_tmr_en),
      .o_expired_c(w_tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_ops        <= '0;
         r_idx        <= '0;
         r_settle     <= '0;
         wen          <= 1'b0;
         haddr        <= '0;
         hdin         <= '0;
         start        <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         running      <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE, ERR: begin
               // Op 0 goes out directly; the rest shift down through r_ops.
               if (go) begin
                  r_state      <= LOAD;
                  r_ops        <= ops >> OP_W;
                  r_idx        <= '0;
                  wen          <= 1'b1;
                  haddr        <= '0;
                  hdin         <= DATA_W'(ops[OP_W-1:0]);
                  result_valid <= 1'b0;
                  timeout_err  <= 1'b0;
                  running      <= 1'b1;
               end
            end
            LOAD: begin
               if (r_idx == LAST_IDX) begin
                  r_state  <= SETTLE;
                  r_settle <= '0;
                  wen      <= 1'b0;
                  haddr    <= '0;
                  hdin     <= '0;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
                  r_ops <= r_ops >> OP_W;
                  haddr <= haddr + ADDR_W'(1);
                  hdin  <= DATA_W'(r_ops[OP_W-1:0]);
               end
            end
            SETTLE: begin
               if (r_settle == LAST_SET) begin
                  r_state <= START;
                  start   <= 1'b1;
               end else begin
                  r_settle <= r_settle + SET_W'(1);
               end
            end
            START: begin
               start   <= 1'b0;
               r_state <= WAIT_HI;
            end
            WAIT_HI: begin
               if (bsy) begin
                  r_state <= WAIT_LO;
               end else if (w_tmr_expired) begin
                  r_state     <= ERR;
                  running     <= 1'b0;
                  timeout_err <= 1'b1;
               end
            end
            WAIT_LO: begin
               if (!bsy) begin
                  r_state <= CAPTURE;
               end else if (w_tmr_expired) begin
                  r_state     <= ERR;
                  running     <= 1'b0;
                  timeout_err <= 1'b1;
               end
            end
            CAPTURE: begin
               result       <= dout;
               result_valid <= 1'b1;
               running      <= 1'b0;
               r_state      <= DONE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Bench for cpu_run_sequencer: timestamp-based run model compared every cycle, plus directed literal checks.
module tb_cpu_run_sequencer;

   localparam int N_OPS = 2;
   localparam int S_CYC = 2;
   localparam int T_OUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic [15:0] ops;
   logic        wen;
   logic [31:0] haddr;
   logic [31:0] hdin;
   logic        start;
   logic        bsy;
   logic [31:0] dout;
   logic [31:0] result;
   logic        result_valid;
   logic        running;
   logic        timeout_err;

   int n_checks = 0;
   int n_pass   = 0;
   int n_starts = 0;
   int n_ticks  = 0;

   always #5 clk = ~clk;

   cpu_run_sequencer #(
      .BSY_TIMEOUT(T_OUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .go          (go),
      .ops         (ops),
      .wen         (wen),
      .haddr       (haddr),
      .hdin        (hdin),
      .start       (start),
      .bsy         (bsy),
      .dout        (dout),
      .result      (result),
      .result_valid(result_valid),
      .running     (running),
      .timeout_err (timeout_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Run model: a run is described by the edge its go was accepted on and the
   // edges on which bsy was first seen high and then low; outputs follow by arithmetic.
   bit          m_init = 0;
   bit          m_busy = 0;
   int          m_e = 0, m_g = 0, m_hi = -1, m_lo = -1;
   logic [15:0] m_ops = '0;
   logic        m_wen, m_start, m_valid, m_running, m_err;
   logic [31:0] m_haddr, m_hdin, m_result;

   always @(posedge clk) begin
      int d;
      int wf;
      m_e++;
      wf = m_g + N_OPS + S_CYC + 1;
      if (rst) begin
         m_busy = 0; m_valid = 0; m_err = 0; m_result = '0; m_init = 1;
      end else if (!m_busy) begin
         if (go) begin
            m_busy = 1; m_g = m_e; m_hi = -1; m_lo = -1;
            m_valid = 0; m_err = 0; m_ops = ops;
         end
      end else if (m_e > wf) begin
         if (m_lo >= 0) begin
            m_result = dout; m_valid = 1; m_busy = 0;
         end else if (m_hi < 0) begin
            if (bsy) m_hi = m_e;
            else if (m_e - wf == T_OUT) begin m_busy = 0; m_err = 1; end
         end else begin
            if (!bsy) m_lo = m_e;
            else if (m_e - m_hi == T_OUT) begin m_busy = 0; m_err = 1; end
         end
      end
      d = m_e - m_g;
      m_running = m_busy;
      m_wen     = m_busy && (d < N_OPS);
      m_haddr   = m_wen ? 32'(d) : 32'd0;
      m_hdin    = m_wen ? 32'((m_ops >> (8 * d)) & 16'h00FF) : 32'd0;
      m_start   = m_busy && (d == N_OPS + S_CYC);
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("cmp_wen",     32'(wen),          32'(m_wen));
         chk("cmp_haddr",   haddr,             m_haddr);
         chk("cmp_hdin",    hdin,              m_hdin);
         chk("cmp_start",   32'(start),        32'(m_start));
         chk("cmp_result",  result,            m_result);
         chk("cmp_valid",   32'(result_valid), 32'(m_valid));
         chk("cmp_running", 32'(running),      32'(m_running));
         chk("cmp_err",     32'(timeout_err),  32'(m_err));
      end
      if (start) n_starts++;
   end

   task automatic tick();
      @(negedge clk);
      n_ticks++;
   endtask

   task automatic wait_start(input string nm);
      for (int i = 0; i < 20 && !start; i++) tick();
      chk(nm, 32'(start), 32'd1);
   endtask

   task automatic wait_valid(input string nm);
      for (int i = 0; i < 40 && !result_valid; i++) tick();
      chk(nm, 32'(result_valid), 32'd1);
   endtask

   initial begin
      int t0;
      int s0;
      rst = 1'b1; go = 1'b0; ops = '0; bsy = 1'b0; dout = '0;
      repeat (3) tick();
      chk("rst_wen",     32'(wen), 32'd0);
      chk("rst_haddr",   haddr, 32'd0);
      chk("rst_valid",   32'(result_valid), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      rst = 1'b0;
      tick();

      // Run 1: ops {7,5}, bsy already high at START and held 10 cycles, dout 35.
      go = 1'b1; ops = {8'd7, 8'd5}; tick(); go = 1'b0;
      chk("r1_wen0", 32'(wen), 32'd1);
      chk("r1_addr0", haddr, 32'd0);
      chk("r1_din0", hdin, 32'd5);
      tick();
      chk("r1_wen1", 32'(wen), 32'd1);
      chk("r1_addr1", haddr, 32'd1);
      chk("r1_din1", hdin, 32'd7);
      tick(); chk("r1_settle0", 32'(wen), 32'd0);
      tick(); chk("r1_settle1", 32'(start), 32'd0);
      tick(); chk("r1_start", 32'(start), 32'd1);
      bsy = 1'b1; dout = 32'd35;
      repeat (10) tick();
      bsy = 1'b0;
      tick(); chk("r1_capture_cyc", 32'(result_valid), 32'd0);
      tick();
      chk("r1_valid", 32'(result_valid), 32'd1);
      chk("r1_result", result, 32'd35);
      chk("r1_running", 32'(running), 32'd0);
      dout = 32'd99;
      tick(); chk("r1_hold", result, 32'd35);

      // Run 2: back-to-back from DONE, ops {255,1}, bsy high one cycle: minimum latency.
      t0 = n_ticks;
      go = 1'b1; ops = {8'd255, 8'd1}; tick(); go = 1'b0;
      chk("r2_valid_drop", 32'(result_valid), 32'd0);
      chk("r2_din0", hdin, 32'd1);
      tick(); chk("r2_din1", hdin, 32'd255);
      repeat (3) tick();
      chk("r2_start", 32'(start), 32'd1);
      tick(); bsy = 1'b1; dout = 32'd256;
      tick(); bsy = 1'b0;
      wait_valid("r2_wait_valid");
      chk("r2_latency", 32'(n_ticks - t0), 32'd9);
      chk("r2_result", result, 32'd256);

      // Run 3: bsy never rises -> ERR after 16 WAIT_HI cycles; go retries.
      go = 1'b1; ops = {8'd3, 8'd2}; tick(); go = 1'b0;
      wait_start("r3_wait_start");
      repeat (16) tick();
      chk("r3_pre_err", 32'(timeout_err), 32'd0);
      chk("r3_pre_running", 32'(running), 32'd1);
      tick();
      chk("r3_err", 32'(timeout_err), 32'd1);
      chk("r3_valid", 32'(result_valid), 32'd0);
      chk("r3_result_kept", result, 32'd256);
      go = 1'b1; ops = {8'd1, 8'd2}; tick(); go = 1'b0;
      chk("r3_err_clr", 32'(timeout_err), 32'd0);
      chk("r3_retry_wen", 32'(wen), 32'd1);
      wait_start("r3b_wait_start");
      tick(); bsy = 1'b1; dout = 32'd3;
      tick(); bsy = 1'b0;
      wait_valid("r3b_wait_valid");
      chk("r3b_result", result, 32'd3);

      // Run 4: reset at LOAD k=1, then go and rst together.
      s0 = n_starts;
      go = 1'b1; ops = {8'd9, 8'd8}; tick(); go = 1'b0;
      tick(); chk("r4_k1", haddr, 32'd1);
      rst = 1'b1; tick();
      chk("r4_wen", 32'(wen), 32'd0);
      chk("r4_haddr", haddr, 32'd0);
      chk("r4_result", result, 32'd0);
      chk("r4_running", 32'(running), 32'd0);
      go = 1'b1; tick(); rst = 1'b0; go = 1'b0;
      chk("r4_rst_wins", 32'(running), 32'd0);
      repeat (10) tick();
      chk("r4_no_start", 32'(n_starts - s0), 32'd0);

      // Run 5: go during WAIT_LO is ignored.
      s0 = n_starts;
      go = 1'b1; ops = {8'd4, 8'd4}; tick(); go = 1'b0;
      wait_start("r5_wait_start");
      tick(); bsy = 1'b1; dout = 32'd77;
      tick(); tick();
      go = 1'b1; tick(); go = 1'b0;
      chk("r5_wait_lo_wen", 32'(wen), 32'd0);
      repeat (3) tick();
      bsy = 1'b0;
      wait_valid("r5_wait_valid");
      chk("r5_result", result, 32'd77);
      repeat (6) tick();
      chk("r5_one_start", 32'(n_starts - s0), 32'd1);
      chk("r5_idle", 32'(running), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
